// File: rtl/fill_blitter_pkg.sv
// Shared types and constants for the rectangle fill blitter.
// Build option: FILL_BLITTER_WAIT_SWAP_EN adds the CCR poll after a swap request.
package fill_blitter_pkg;
  typedef enum logic [2:0] {IDLE, REQ, FILL, SWAP, POLL, DONE} state_t;

  localparam int FB_COLS  = 256;
  localparam int FB_LINES = 192;

  localparam logic [15:0] FB_BASE = 16'h4000;
  localparam logic [15:0] CCR_ADR = 16'h3800;

  localparam int CCR_BUF     = 0;
  localparam int CCR_CPU_FIN = 1;
  localparam int CCR_GPU_FIN = 2;

  localparam logic [7:0] SWAP_VAL = 8'(1 << CCR_CPU_FIN);

  // Last coordinate of a span, saturated to the last valid index below limit.
  function automatic logic [7:0] clip_end(input logic [7:0] start, input logic [7:0] len_m1,
                                          input int limit);
    logic [8:0] sum;
    sum = {1'b0, start} + {1'b0, len_m1};
    return (sum > 9'(limit - 1)) ? 8'(limit - 1) : sum[7:0];
  endfunction
endpackage

// File: rtl/fill_blitter_walker.sv
// Raster walker: x/y counters over the clipped rectangle, stepping left-to-right
// then top-to-bottom on each adv pulse.
module fill_blitter_walker import fill_blitter_pkg::*; (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic       adv,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] wm1,
  input  logic [7:0] hm1,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       last,
  output logic       empty
);
  logic [7:0] x_org, x_end, y_end;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      x     <= '0;
      y     <= '0;
      x_org <= '0;
      x_end <= '0;
      y_end <= '0;
      empty <= 1'b0;
    end else if (load) begin
      x     <= x0;
      y     <= y0;
      x_org <= x0;
      x_end <= clip_end(x0, wm1, FB_COLS);
      y_end <= clip_end(y0, hm1, FB_LINES);
      empty <= (y0 >= 8'(FB_LINES));
    end else if (adv) begin
      if (x == x_end) begin
        x <= x_org;
        y <= y + 8'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

  assign last = (x == x_end) && (y == y_end);
endmodule

// File: rtl/fill_blitter.sv
// Second bus master that fills a clipped framebuffer rectangle with one colour
// and optionally requests a buffer swap. Option: FILL_BLITTER_WAIT_SWAP_EN.
module fill_blitter import fill_blitter_pkg::*; (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  X0,
  input  logic [7:0]  Y0,
  input  logic [7:0]  Wm1,
  input  logic [7:0]  Hm1,
  input  logic [7:0]  Colour,
  input  logic        SwapOnDone,
  input  logic        BusGnt,
  input  logic [7:0]  DataIn,
  output logic        BusReq,
  output logic [15:0] AdrOut,
  output logic [7:0]  DataOut,
  output logic        WrtMem,
  output logic        LdMem,
  output logic        Busy,
  output logic        Done
);
  state_t     state;
  logic [7:0] colour;
  logic       swap;
  logic [7:0] x, y;
  logic       last, empty;
  logic       load, adv;

  assign load = (state == IDLE) && Start;
  assign adv  = (state == FILL) && BusGnt;

  fill_blitter_walker u_walker (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (load),
    .adv   (adv),
    .x0    (X0),
    .y0    (Y0),
    .wm1   (Wm1),
    .hm1   (Hm1),
    .x     (x),
    .y     (y),
    .last  (last),
    .empty (empty)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      colour <= '0;
      swap   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          colour <= Colour;
          swap   <= SwapOnDone;
          state  <= REQ;
        end
        REQ: if (BusGnt) begin
          if (!empty)    state <= FILL;
          else if (swap) state <= SWAP;
          else           state <= DONE;
        end
        FILL: if (BusGnt && last) state <= swap ? SWAP : DONE;
`ifdef FILL_BLITTER_WAIT_SWAP_EN
        SWAP: if (BusGnt) state <= POLL;
        // Display clears the CPU-finished bit once it has flipped buffers at vsync.
        POLL: if (BusGnt && !DataIn[CCR_CPU_FIN]) state <= DONE;
`else
        SWAP: if (BusGnt) state <= DONE;
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by the live grant so a dropped grant never leaks a cycle.
  assign BusReq = (state == REQ) || (state == FILL) || (state == SWAP) || (state == POLL);
  assign WrtMem = BusGnt && ((state == FILL) || (state == SWAP));
  assign Busy   = (state != IDLE);
  assign Done   = (state == DONE);

`ifdef FILL_BLITTER_WAIT_SWAP_EN
  logic unused_data;
  assign LdMem       = BusGnt && (state == POLL);
  assign unused_data = ^{DataIn[7:2], DataIn[0]};
`else
  logic unused_data;
  assign LdMem       = 1'b0;
  assign unused_data = ^DataIn;
`endif

  always_comb begin
    AdrOut  = '0;
    DataOut = '0;
    case (state)
      FILL: begin
        AdrOut  = FB_BASE + {y, x};
        DataOut = colour;
      end
      SWAP: begin
        AdrOut  = CCR_ADR;
        DataOut = SWAP_VAL;
      end
      POLL:    AdrOut = CCR_ADR;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fill_blitter.sv
// Randomized bench for fill_blitter: expected write streams come from a
// rectangle/clipping model; a bus monitor records every strobe.
module tb_fill_blitter;
  logic        Clk = 1'b0, Reset = 1'b0, Start = 1'b0;
  logic [7:0]  X0 = '0, Y0 = '0, Wm1 = '0, Hm1 = '0, Colour = '0;
  logic        SwapOnDone = 1'b0, BusGnt = 1'b0;
  logic [7:0]  DataIn;
  logic        BusReq, WrtMem, LdMem, Busy, Done;
  logic [15:0] AdrOut;
  logic [7:0]  DataOut;

  fill_blitter dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .X0(X0), .Y0(Y0), .Wm1(Wm1), .Hm1(Hm1),
    .Colour(Colour), .SwapOnDone(SwapOnDone), .BusGnt(BusGnt), .DataIn(DataIn),
    .BusReq(BusReq), .AdrOut(AdrOut), .DataOut(DataOut), .WrtMem(WrtMem), .LdMem(LdMem),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Display model: CPU-finished bit reads back set for 5 polls after a swap request.
  int reads_left = 0;
  assign DataIn = (reads_left > 0) ? 8'h02 : 8'h00;
  always @(posedge Clk) begin
    if (WrtMem && BusGnt && AdrOut == 16'h3800) reads_left <= 5;
    else if (LdMem && BusGnt && reads_left > 0) reads_left <= reads_left - 1;
  end

  logic [23:0] wr_q[$];
  int          wr_cyc[$];
  int          done_cnt = 0, done_cyc = 0, ld_cnt = 0, viol = 0;

  always @(negedge Clk) begin
    if (WrtMem) begin
      wr_q.push_back({AdrOut, DataOut});
      wr_cyc.push_back(cyc);
    end
    if (LdMem) begin
      ld_cnt++;
      if (AdrOut != 16'h3800) viol++;
    end
    if ((WrtMem || LdMem) && !BusGnt) viol++;
    if (WrtMem && LdMem) viol++;
    if (Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic gnt(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
    done_cnt = 0;
    ld_cnt   = 0;
    viol     = 0;
  endtask

  task automatic run(input int x0, input int y0, input int wm1, input int hm1,
                     input logic [7:0] col, input logic swp, input int mode);
    logic [23:0] exp_q[$];
    int n, base, k, xend, yend, exp_ld;
    if (y0 < 192) begin
      xend = (x0 + wm1 > 255) ? 255 : x0 + wm1;
      yend = (y0 + hm1 > 191) ? 191 : y0 + hm1;
      for (int yy = y0; yy <= yend; yy++)
        for (int xx = x0; xx <= xend; xx++)
          exp_q.push_back({16'(16'h4000 + yy * 256 + xx), col});
    end
    n = exp_q.size();
    if (swp) exp_q.push_back({16'h3800, 8'h02});
`ifdef FILL_BLITTER_WAIT_SWAP_EN
    exp_ld = swp ? 6 : 0;
`else
    exp_ld = 0;
`endif
    clear_log();
    @(posedge Clk); #1;
    X0 = 8'(x0); Y0 = 8'(y0); Wm1 = 8'(wm1); Hm1 = 8'(hm1);
    Colour = col; SwapOnDone = swp; Start = 1'b1;
    BusGnt = gnt(mode, 0);
    base = cyc;
    k = 1;
    while (done_cnt == 0 && k < 3000) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      X0 = 8'($urandom); Y0 = 8'($urandom); Colour = 8'($urandom);
      if (k == 1) chk("busy_set", Busy, 1);
      if (mode == 2 && k == 3) begin
        Start = 1'b1;
        SwapOnDone = 1'($urandom);
      end
      BusGnt = gnt(mode, k);
      @(negedge Clk); #1;
      k++;
    end
    chk("done_seen", done_cnt, 1);
    @(posedge Clk); #1;
    Start = 1'b0;
    BusGnt = 1'b0;
    chk("busy_clr", Busy, 0);
    repeat (2) @(posedge Clk);
    #1;
    chk("done_pulse", done_cnt, 1);
    chk("nwr", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) chk("wr", wr_q[i], exp_q[i]);
    chk("strobe", viol, 0);
    chk("ldcnt", ld_cnt, exp_ld);
    if (mode == 0) begin
      chk("done_lat", done_cyc - base, n + 2 + int'(swp) + exp_ld);
      if (wr_cyc.size() > 0) chk("first_wr", wr_cyc[0] - base, 2);
    end
  endtask

  task automatic reset_test();
    int k;
    clear_log();
    @(posedge Clk); #1;
    X0 = 8'd20; Y0 = 8'd30; Wm1 = 8'd7; Hm1 = 8'd0; Colour = 8'h5A;
    SwapOnDone = 1'b1; Start = 1'b1; BusGnt = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    k = 0;
    while (wr_q.size() < 3 && k < 50) begin
      @(negedge Clk); #1;
      k++;
    end
    chk("rst_pre_nwr", wr_q.size(), 3);
    Reset = 1'b0;
    #1;
    chk("rst_outs", {BusReq, WrtMem, LdMem, Busy, Done, AdrOut, DataOut}, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    chk("rst_nwr", wr_q.size(), 3);
    chk("rst_nodone", done_cnt, 0);
    BusGnt = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_outs", {BusReq, WrtMem, LdMem, Busy, Done, AdrOut, DataOut}, 0);
    Reset = 1'b1;
    run(10, 5, 2, 1, 8'hE3, 1'b0, 0);
    run(250, 190, 9, 9, 8'hC1, 1'b0, 0);
    run(0, 200, 3, 3, 8'h77, 1'b1, 0);
    run(100, 50, 3, 0, 8'hF0, 1'b0, 1);
    run(7, 191, 0, 0, 8'h11, 1'b1, 0);
    reset_test();
    run(20, 30, 7, 0, 8'h5A, 1'b1, 0);
    for (int t = 0; t < 25; t++)
      run($urandom_range(0, 255), $urandom_range(0, 210), $urandom_range(0, 15),
          $urandom_range(0, 15), 8'($urandom), 1'($urandom), $urandom_range(0, 2));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
